// File: rtl/w21_col_mac_reader_if.sv
// Handshake and ROM bus between a weight-column MAC reader and its environment.
// The DUT uses the slave view; the activation source, ROM and consumer use master.
interface w21_col_mac_reader_if #(
  parameter int unsigned ADDR_W = 9,
  parameter int unsigned W_W    = 21,
  parameter int unsigned X_W    = 8,
  parameter int unsigned ACC_W  = 38
) ();
  logic              start;
  logic              x_valid;
  logic [X_W-1:0]    x_data;
  logic              x_ready;
  logic [ADDR_W-1:0] adrs_clm;
  logic [W_W-1:0]    w_in;
  logic              out_valid;
  logic [ACC_W-1:0]  out_data;
  logic              out_ready;
  logic              busy;

  modport slave (
    input  start, x_valid, x_data, w_in, out_ready,
    output x_ready, adrs_clm, out_valid, out_data, busy
  );

  modport master (
    output start, x_valid, x_data, w_in, out_ready,
    input  x_ready, adrs_clm, out_valid, out_data, busy
  );
endinterface

// File: rtl/w21_col_mac_reader.sv
// Streams activations against a combinational weight-column ROM and accumulates
// the exact signed dot product, presented on a valid/ready result port.
module w21_col_mac_reader #(
  parameter int unsigned DEPTH  = 300,
  parameter int unsigned ADDR_W = 9,
  parameter int unsigned W_W    = 21,
  parameter int unsigned X_W    = 8,
  parameter int unsigned ACC_W  = 38
) (
  input  logic                    clk,
  input  logic                    rst_n,
  w21_col_mac_reader_if.slave     bus_io
);

  localparam int unsigned PW = W_W + X_W;
  localparam logic [ADDR_W-1:0] LastIdx = ADDR_W'(DEPTH - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  logic [ADDR_W-1:0]   adrs_q, adrs_d;
  logic [PW-1:0]       prod_q, prod_d;
  logic                prod_v_q, prod_v_d;
  logic [ACC_W-1:0]    acc_q, acc_d;

  logic [PW-1:0]       x_ext, w_ext, prod_now;
  logic [ACC_W-1:0]    prod_acc_ext;

  // Both operands sign-extended to the full product width, so the truncated
  // product is the exact signed result.
  assign x_ext        = {{W_W{bus_io.x_data[X_W-1]}}, bus_io.x_data};
  assign w_ext        = {{X_W{bus_io.w_in[W_W-1]}}, bus_io.w_in};
  assign prod_now     = x_ext * w_ext;
  assign prod_acc_ext = {{(ACC_W - PW){prod_q[PW-1]}}, prod_q};

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    adrs_d   = adrs_q;
    prod_d   = prod_q;
    prod_v_d = 1'b0;
    acc_d    = prod_v_q ? (acc_q + prod_acc_ext) : acc_q;

    unique case (state_q)
      StIdle: begin
        if (bus_io.start) begin
          state_d = StRun;
          acc_d   = '0;
          cnt_d   = '0;
          adrs_d  = '0;
        end
      end
      StRun: begin
        if (bus_io.x_valid) begin
          prod_d   = prod_now;
          prod_v_d = 1'b1;
          cnt_d    = cnt_q + 1'b1;
          adrs_d   = cnt_q + 1'b1;
          if (cnt_q == LastIdx) begin
            adrs_d  = '0;
            state_d = StDrain;
          end
        end
      end
      StDrain: state_d = StDone;
      StDone: begin
        if (bus_io.out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      adrs_q   <= '0;
      prod_q   <= '0;
      prod_v_q <= 1'b0;
      acc_q    <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      adrs_q   <= adrs_d;
      prod_q   <= prod_d;
      prod_v_q <= prod_v_d;
      acc_q    <= acc_d;
    end
  end

  assign bus_io.x_ready   = (state_q == StRun);
  assign bus_io.busy      = (state_q != StIdle);
  assign bus_io.out_valid = (state_q == StDone);
  assign bus_io.out_data  = (state_q == StDone) ? acc_q : '0;
  assign bus_io.adrs_clm  = adrs_q;

endmodule

// File: tb/tb_w21_col_mac_reader.sv
// Directed plus randomized bench for w21_col_mac_reader against a bench-side
// ROM and a plain-arithmetic dot-product model.
module tb_w21_col_mac_reader;

  localparam int DEPTH = 300;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  bit   stub = 1'b0;

  always #5 clk = ~clk;

  w21_col_mac_reader_if #(.ADDR_W(9), .W_W(21), .X_W(8), .ACC_W(38)) bif ();

  w21_col_mac_reader dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus_io (bif)
  );

  // Column ROM: fixed words at 0 and 1, hashed contents elsewhere.
  function automatic logic [20:0] rom_word(input logic [8:0] a, input bit s);
    logic [31:0] h;
    if (s) return 21'h100000;
    if (a == 9'd0) return 21'd14;
    if (a == 9'd1) return -21'sd231;
    h = {23'd0, a} * 32'd2654435761;
    return h[27:7];
  endfunction

  always_comb bif.w_in = rom_word(bif.adrs_clm, stub);

  int passes = 0;
  int total  = 0;
  logic signed [7:0] xs [DEPTH];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic longint model_dot();
    longint s = 0;
    for (int i = 0; i < DEPTH; i++)
      s += longint'(xs[i]) * longint'($signed(rom_word(9'(i), stub)));
    return s;
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    bif.start = 1'b0;
    bif.x_valid = 1'b0;
    bif.x_data = '0;
    bif.out_ready = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_busy"}, 64'(bif.busy), 64'd0);
    check({tag, "_xrdy"}, 64'(bif.x_ready), 64'd0);
    check({tag, "_oval"}, 64'(bif.out_valid), 64'd0);
    check({tag, "_adrs"}, 64'(bif.adrs_clm), 64'd0);
    check({tag, "_odat"}, 64'(bif.out_data), 64'd0);
  endtask

  // Runs one dot product to DONE; stop_at < DEPTH aborts after that many beats.
  task automatic run_dot(input string tag, input bit gaps, input longint expv,
                         input bit handshake, input int stop_at);
    int idx = 0;
    int budget = 4000;
    int adrs_bad = 0;
    logic [37:0] e;
    bit v;
    e = expv[37:0];
    bif.start = 1'b1;
    tick();
    bif.start = 1'b0;
    check({tag, "_run_busy"}, 64'(bif.busy), 64'd1);
    check({tag, "_run_xrdy"}, 64'(bif.x_ready), 64'd1);
    while (idx < stop_at && budget > 0) begin
      v = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
      bif.x_valid = v;
      bif.x_data = xs[idx];
      if (bif.adrs_clm !== 9'(idx) || bif.x_ready !== 1'b1) adrs_bad++;
      tick();
      if (v) idx++;
      budget--;
    end
    check({tag, "_addr_track"}, 64'(adrs_bad), 64'd0);
    check({tag, "_beats"}, 64'(idx), 64'(stop_at));
    if (stop_at < DEPTH) return;
    // Extra beats stay offered and must not be taken.
    bif.x_valid = gaps;
    check({tag, "_drain_oval"}, 64'(bif.out_valid), 64'd0);
    check({tag, "_drain_xrdy"}, 64'(bif.x_ready), 64'd0);
    tick();
    check({tag, "_done_oval"}, 64'(bif.out_valid), 64'd1);
    check({tag, "_done_xrdy"}, 64'(bif.x_ready), 64'd0);
    check({tag, "_result"}, 64'(bif.out_data), 64'(e));
    bif.x_valid = 1'b0;
    if (handshake) begin
      bif.out_ready = 1'b1;
      tick();
      bif.out_ready = 1'b0;
      check_idle({tag, "_post"});
    end
  endtask

  initial begin
    int stable_bad;
    logic [37:0] held;
    longint ref_v;

    do_reset();
    check_idle("reset");

    // Single nonzero beat at index 0.
    foreach (xs[i]) xs[i] = 8'sd0;
    xs[0] = 8'sd1;
    run_dot("idx0", 1'b0, 64'sd14, 1'b1, DEPTH);

    // Sign handling at index 1.
    xs[0] = 8'sd0;
    xs[1] = 8'sd1;
    run_dot("idx1_p1", 1'b0, -64'sd231, 1'b1, DEPTH);
    xs[1] = -8'sd128;
    run_dot("idx1_m128", 1'b0, 64'sd29568, 1'b1, DEPTH);

    // Random columns with gapped streams.
    for (int r = 0; r < 3; r++) begin
      foreach (xs[i]) xs[i] = 8'($urandom);
      ref_v = model_dot();
      run_dot($sformatf("rand%0d", r), 1'b1, ref_v, 1'b1, DEPTH);
    end

    // Worst-case magnitude with a constant -2^20 ROM.
    stub = 1'b1;
    foreach (xs[i]) xs[i] = -8'sd128;
    run_dot("worst", 1'b0, 64'sd40265318400, 1'b1, DEPTH);
    stub = 1'b0;

    // Output backpressure: DONE holds, start and beats ignored.
    foreach (xs[i]) xs[i] = 8'($urandom);
    ref_v = model_dot();
    run_dot("bp", 1'b0, ref_v, 1'b0, DEPTH);
    held = bif.out_data;
    stable_bad = 0;
    bif.start = 1'b1;
    bif.x_valid = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (bif.out_data !== held || bif.out_valid !== 1'b1 || bif.x_ready !== 1'b0 ||
          bif.busy !== 1'b1) stable_bad++;
    end
    check("bp_stable", 64'(stable_bad), 64'd0);
    bif.start = 1'b0;
    bif.x_valid = 1'b0;
    bif.out_ready = 1'b1;
    tick();
    bif.out_ready = 1'b0;
    check_idle("bp_release");
    // Fastest restart right after the handshake.
    bif.start = 1'b1;
    tick();
    bif.start = 1'b0;
    check("restart_busy", 64'(bif.busy), 64'd1);
    check("restart_xrdy", 64'(bif.x_ready), 64'd1);
    do_reset();
    check_idle("restart_reset");

    // Reset mid-run after beat 150, then a fresh run.
    foreach (xs[i]) xs[i] = 8'($urandom);
    run_dot("midrst", 1'b1, 0, 1'b0, 151);
    rst_n = 1'b0;
    bif.x_valid = 1'b0;
    tick();
    check_idle("midrst_idle");
    rst_n = 1'b1;
    ref_v = model_dot();
    run_dot("fresh", 1'b1, ref_v, 1'b1, DEPTH);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule

// File: doc/w21_col_mac_reader.md
# w21_col_mac_reader

Sequential reader and consumer for a 21-bit weight-column ROM (9-bit column address, 300 entries, addresses 0..299).
- Accepts a stream of 300 signed 8-bit activations.
- Drives the ROM column address in step with the stream and multiplies each activation by the returned signed weight.
- Accumulates a full-precision dot product and presents it on a valid/ready output port.
- Sits between the activation source and the next layer, one instance per weight column.

## Interface
Parameters:
- DEPTH, 300: number of weights and activations per dot product; the last address is DEPTH-1.
- ADDR_W, 9: ROM address width.
- W_W, 21: weight width, signed two's complement.
- X_W, 8: activation width, signed two's complement.
- ACC_W, 38: accumulator and result width. Must be at least W_W+X_W+ceil(log2(DEPTH)).

Ports:
- clk, input, 1: single clock; all state updates on the rising edge.
- rst_n, input, 1: reset, synchronous, active-low.
- start, input, 1: begin a dot product; sampled only in IDLE.
- x_valid, input, 1: activation beat valid.
- x_data, input, X_W: signed activation.
- x_ready, output, 1: block accepts a beat this cycle.
- adrs_clm, output, ADDR_W: registered address to the ROM.
- w_in, input, W_W: combinational ROM data for the current adrs_clm.
- out_valid, output, 1: result valid.
- out_data, output, ACC_W: signed dot product.
- out_ready, input, 1: downstream accepts the result.
- busy, output, 1: high in every state except IDLE.

## Operation
Internal registers:
- cnt: 9-bit beat counter.
- prod_r: (W_W+X_W)-bit signed product register.
- prod_v: valid flag for prod_r.
- acc: ACC_W-bit signed accumulator.

State machine IDLE -> RUN -> DRAIN -> DONE -> IDLE:
- IDLE
  - x_ready=0, out_valid=0, adrs_clm=0.
  - start=1 -> RUN; acc<=0, cnt<=0, prod_v<=0.
- RUN
  - x_ready=1, adrs_clm=cnt.
  - On x_valid&x_ready: prod_r<=x_data*w_in (both signed, full 29-bit product), prod_v<=1, cnt<=cnt+1, adrs_clm<=cnt+1.
  - When the accepted beat has cnt==DEPTH-1: adrs_clm<=0 and the state moves to DRAIN.
  - No beat accepted: prod_v<=0; cnt and adrs_clm hold (stall).
- DRAIN
  - x_ready=0, prod_v<=0.
  - Next state DONE.
- DONE
  - out_valid=1, out_data=acc, held stable.
  - out_ready=1 -> IDLE.

Accumulation and arithmetic:
- Every cycle with prod_v=1: acc<=acc+sign_extend(prod_r).
- All arithmetic is exact; no saturation or rounding is needed because ACC_W covers the worst case.

Boundary conditions:
- start outside IDLE is ignored.
- x_valid outside RUN is ignored; no beat is consumed.
- out_ready outside DONE is ignored.
- Exactly DEPTH beats are consumed per start; extra beats wait for the next run.
- rst_n=0 at any cycle, including mid-RUN or DONE, forces IDLE on the next edge and discards partial results.

## Timing
Reset values:
- state=IDLE, cnt=0, adrs_clm=0.
- x_ready=0, out_valid=0, busy=0.
- out_data=0 (acc=0), prod_r=0, prod_v=0.

Cycle-level behaviour:
- ROM data path: w_in must be settled within the same cycle that adrs_clm is presented. The ROM is purely combinational, so there is zero ROM latency.
- start at edge S: busy=1 and x_ready=1 from cycle S+1.
- Throughput: one beat per cycle; minimum run is DEPTH cycles of RUN.
- Last beat accepted at edge T:
  - edge T+1: the final product is accumulated and the state moves to DONE.
  - out_valid is high from cycle T+1.
- out_valid, out_data and busy drop the cycle after the out_ready handshake.
- Fastest restart: a new start is accepted the cycle after the handshake.
- busy stays high through DONE.

## Test plan
- Single nonzero beat at index 0: reset, start, beat 0 with x=1, beats 1..299 with x=0, real ROM -> out_data=14, out_valid 2 edges after the last beat.
- Sign handling at index 1: only beat 1 nonzero with x=1 -> out_data=-231. Repeat with x=-128 -> out_data=29568.
- Full column with gapped stream: random signed x with random x_valid gaps -> out_data equals the reference-model dot product; adrs_clm holds during gaps; exactly 300 beats are consumed.
- Worst-case magnitude: stub ROM returns -2^20 at every address, x=-128 for all beats -> out_data=40265318400 with no overflow.
- Output backpressure: hold out_ready=0 for 10 cycles in DONE -> out_data stable, start ignored, x_ready=0. Then out_ready=1 -> IDLE next cycle, busy=0.
- Reset mid-run: assert rst_n=0 after beat 150 -> next cycle IDLE with all outputs at reset values. A fresh run then produces the correct result.
